// File: rtl/dlf_band_ctrl_if.sv
// rtl/dlf_band_ctrl_if.sv - CSR, phase-error and DCO-word bundle for dlf_band_ctrl
//
// Purpose: carries the loop-filter CSRs, the TDC phase-error sample and the
// filter/band outputs between the control side and dlf_band_ctrl.
// Signals:
//   csr_dlf_en, csr_band_acq_en   filter enable, band-search enable
//   csr_dlf_kp_shft/ki_shft [2:0] proportional / integral left shifts
//   csr_band_init [7:0]           band loaded while idle
//   phe [PHE_W-1:0], phe_vld      signed phase error and its strobe
//   dlf_out [15:0], band [7:0]    filter and band words to the FLB
//   band_lock, band_lim           tracking reached, sticky band-edge flag
// Modports: master drives CSRs and phe; slave is the controller.
interface dlf_band_ctrl_if #(
  parameter int PHE_W = 10
);
  logic             csr_dlf_en;
  logic             csr_band_acq_en;
  logic [2:0]       csr_dlf_kp_shft;
  logic [2:0]       csr_dlf_ki_shft;
  logic [7:0]       csr_band_init;
  logic [PHE_W-1:0] phe;
  logic             phe_vld;
  logic [15:0]      dlf_out;
  logic [7:0]       band;
  logic             band_lock;
  logic             band_lim;

  modport master (
    output csr_dlf_en, csr_band_acq_en, csr_dlf_kp_shft, csr_dlf_ki_shft,
           csr_band_init, phe, phe_vld,
    input  dlf_out, band, band_lock, band_lim
  );

  modport slave (
    input  csr_dlf_en, csr_band_acq_en, csr_dlf_kp_shft, csr_dlf_ki_shft,
           csr_band_init, phe, phe_vld,
    output dlf_out, band, band_lock, band_lim
  );
endinterface

// File: rtl/dlf_band_ctrl.sv
// rtl/dlf_band_ctrl.sv - DPLL proportional-integral loop filter with coarse band acquisition
//
// Purpose: filters the TDC phase error into a 16-bit DCO fine word and, when
// band acquisition is compiled in, steps the coarse band until the fine word
// leaves its saturation zones, then freezes the band and keeps tracking.
// Ports:
//   ref_clk   filter clock
//   rst       asynchronous active-high reset
//   bus       dlf_band_ctrl_if.slave (CSRs, phe/phe_vld in; dlf_out, band,
//             band_lock, band_lim out; all outputs registered)
// Build option: define DLF_BAND_ACQ_EN to compile in the ACQ/SETTLE band
// search and band_lim; without it band follows csr_band_init and the FSM
// goes straight from IDLE to TRACK.
module dlf_band_ctrl #(
  parameter int PHE_W      = 10,
  parameter int INT_W      = 24,
  parameter int LOCK_CNT   = 32,
  parameter int SETTLE_CYC = 16
) (
  input  logic            ref_clk,
  input  logic            rst,
  dlf_band_ctrl_if.slave  bus
);

  // Integrator sum needs two guard bits above INT_W to detect overflow.
  localparam int S_W = INT_W + 2;
  // Output sum: widest of (int>>>8) and (phe<<<7), plus headroom for the
  // 0x8000 offset and two signed additions.
  localparam int Y_W = (((INT_W - 8) > (PHE_W + 7)) ? (INT_W - 8) : (PHE_W + 7)) + 3;

  localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_TRACK  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic signed [INT_W-1:0]  int_q, int_d;
  logic [15:0]              dlf_q, dlf_d;
  logic [7:0]               band_q, band_d;
  logic                     lock_q, lock_d;

`ifdef DLF_BAND_ACQ_EN
  localparam int LC_W = (LOCK_CNT > 2) ? $clog2(LOCK_CNT) : 1;
  localparam int SC_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;

  logic                     lim_q, lim_d;
  logic [LC_W-1:0]          lock_cnt_q, lock_cnt_d;
  logic [SC_W-1:0]          settle_cnt_q, settle_cnt_d;
  logic                     sat_hi, sat_lo;
`else
  logic                     unused_acq_en;
  assign unused_acq_en = bus.csr_band_acq_en;
`endif

  // Filter datapath: evaluated every cycle, committed only on phe_vld.
  logic signed [S_W-1:0]    ki_term;
  logic [S_W-1:0]           int_sum;
  logic signed [INT_W-1:0]  int_next;
  logic [Y_W-1:0]           int_shr;
  logic [Y_W-1:0]           kp_term;
  logic [Y_W-1:0]           y_sum;
  logic [15:0]              dlf_new;

  always_comb begin
    ki_term = {{(S_W-PHE_W){bus.phe[PHE_W-1]}}, bus.phe} <<< bus.csr_dlf_ki_shft;
    int_sum = {{2{int_q[INT_W-1]}}, int_q} + ki_term;
    // The three top bits must agree for the sum to fit in INT_W.
    if ((&int_sum[S_W-1:INT_W-1]) || !(|int_sum[S_W-1:INT_W-1])) begin
      int_next = int_sum[INT_W-1:0];
    end else if (int_sum[S_W-1]) begin
      int_next = INT_MIN;
    end else begin
      int_next = INT_MAX;
    end

    // Taking the upper bits is the arithmetic shift right by 8.
    int_shr = {{(Y_W-(INT_W-8)){int_next[INT_W-1]}}, int_next[INT_W-1:8]};
    kp_term = {{(Y_W-PHE_W){bus.phe[PHE_W-1]}}, bus.phe} << bus.csr_dlf_kp_shft;
    y_sum   = {{(Y_W-16){1'b0}}, 16'h8000} + int_shr + kp_term;

    if (y_sum[Y_W-1]) begin
      dlf_new = 16'h0000;
    end else if (|y_sum[Y_W-2:16]) begin
      dlf_new = 16'hFFFF;
    end else begin
      dlf_new = y_sum[15:0];
    end
  end

`ifdef DLF_BAND_ACQ_EN
  assign sat_hi = (dlf_new >= 16'hF000);
  assign sat_lo = (dlf_new <= 16'h0FFF);
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    dlf_d   = dlf_q;
    band_d  = band_q;
`ifdef DLF_BAND_ACQ_EN
    lim_d        = lim_q;
    lock_cnt_d   = lock_cnt_q;
    settle_cnt_d = settle_cnt_q;
`endif

    // Dropping the enable behaves exactly like sitting in IDLE, so both
    // share the same clearing actions.
    if (!bus.csr_dlf_en || (state_q == ST_IDLE)) begin
      int_d  = '0;
      dlf_d  = 16'h8000;
      band_d = bus.csr_band_init;
`ifdef DLF_BAND_ACQ_EN
      lim_d        = 1'b0;
      lock_cnt_d   = '0;
      settle_cnt_d = '0;
`endif
      if (!bus.csr_dlf_en) begin
        state_d = ST_IDLE;
      end else begin
`ifdef DLF_BAND_ACQ_EN
        state_d = bus.csr_band_acq_en ? ST_ACQ : ST_TRACK;
`else
        state_d = ST_TRACK;
`endif
      end
    end else begin
      case (state_q)
`ifdef DLF_BAND_ACQ_EN
        ST_ACQ: begin
          if (bus.phe_vld) begin
            int_d = int_next;
            dlf_d = dlf_new;
            if (sat_hi && (band_q != 8'hFF)) begin
              band_d       = band_q + 8'd1;
              int_d        = '0;
              dlf_d        = 16'h8000;
              settle_cnt_d = '0;
              state_d      = ST_SETTLE;
            end else if (sat_lo && (band_q != 8'h00)) begin
              band_d       = band_q - 8'd1;
              int_d        = '0;
              dlf_d        = 16'h8000;
              settle_cnt_d = '0;
              state_d      = ST_SETTLE;
            end else if (sat_hi || sat_lo) begin
              // Saturated at a band edge: nowhere left to step.
              lim_d      = 1'b1;
              lock_cnt_d = '0;
            end else if (lock_cnt_q == LC_W'(LOCK_CNT - 1)) begin
              lock_cnt_d = '0;
              state_d    = ST_TRACK;
            end else begin
              lock_cnt_d = lock_cnt_q + LC_W'(1);
            end
          end
        end

        ST_SETTLE: begin
          // DCO is given time to respond to the new band; phe is ignored.
          int_d = '0;
          dlf_d = 16'h8000;
          if (settle_cnt_q == SC_W'(SETTLE_CYC - 1)) begin
            lock_cnt_d = '0;
            state_d    = ST_ACQ;
          end else begin
            settle_cnt_d = settle_cnt_q + SC_W'(1);
          end
        end
`endif

        ST_TRACK: begin
          if (bus.phe_vld) begin
            int_d = int_next;
            dlf_d = dlf_new;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

`ifndef DLF_BAND_ACQ_EN
    band_d = bus.csr_band_init;
`endif

    // band_lock is registered alongside the state so it rises on the TRACK entry edge.
    lock_d = (state_d == ST_TRACK);
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      int_q   <= '0;
      dlf_q   <= 16'h8000;
      band_q  <= 8'h80;
      lock_q  <= 1'b0;
`ifdef DLF_BAND_ACQ_EN
      lim_q        <= 1'b0;
      lock_cnt_q   <= '0;
      settle_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      dlf_q   <= dlf_d;
      band_q  <= band_d;
      lock_q  <= lock_d;
`ifdef DLF_BAND_ACQ_EN
      lim_q        <= lim_d;
      lock_cnt_q   <= lock_cnt_d;
      settle_cnt_q <= settle_cnt_d;
`endif
    end
  end

  assign bus.dlf_out   = dlf_q;
  assign bus.band      = band_q;
  assign bus.band_lock = lock_q;
`ifdef DLF_BAND_ACQ_EN
  assign bus.band_lim  = lim_q;
`else
  assign bus.band_lim  = 1'b0;
`endif

endmodule
